mode_sequencer: RTL and testbench
=================================

// Module: mode_sequencer
// PURPOSE
//  Central controller of the watch design. Sits between the button pins and the
//  watch/stopwatch/timer counter datapaths.
//  Debounces the 8 buttons, runs the mode/setting FSM and issues one-cycle strobes.
//  Selects the source shown on dig0..dig3, owns led[7:0] and arbitrates the speaker.
// PARAMETERS
//  DEB_CYCLES  2      cycles btn must be stable high before a press is accepted (>=1)
//  TONE_DIV    4      speaker toggles every TONE_DIV cycles while alarm is active
//  ALARM_TICKS 10     tick_1hz pulses the alarm sounds before auto-stop
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous reset, active high
//  btn         in   8  buttons, active high (top_level inverts the board pins)
//  tick_1hz    in   1  one-cycle 1 Hz pulse from the prescaler
//  tm_zero     in   1  timer counter is at 00:00
//  mode        out  2  0 WATCH, 1 STOPWATCH, 2 TIMER (display mux select)
//  set_field   out  2  0 none, 1 hours/minutes field, 2 minutes/seconds field
//  inc_p       out  1  one-cycle increment strobe for the field in set_field
//  dec_p       out  1  one-cycle decrement strobe for the field in set_field
//  sw_run      out  1  stopwatch counting enable (level)
//  sw_clr      out  1  one-cycle stopwatch clear
//  tm_run      out  1  timer countdown enable (level)
//  blink       out  1  display blank enable for the edited field (toggles on tick_1hz)
//  speaker     out  1  speaker drive
//  led         out  8  one-hot state indicator, led[i] = (state code == i)
// BEHAVIOUR
//  Reset: state=WATCH; all strobes, sw_run, tm_run, blink and speaker = 0;
//   mode=0; set_field=0; led=8'h01; debounce counters cleared.
//  Debounce (per bit): counter counts while btn[i]=1 and clears when btn[i]=0.
//   press[i] pulses one cycle when the count reaches DEB_CYCLES.
//   No further press[i] until btn[i] has returned to 0.
//  Only one press is acted on per cycle: lowest index wins, others in the same cycle are dropped.
//  Latency: FSM registers on the cycle after press; strobes are asserted in that same cycle.
//  Button map: 0 watch, 1 stopwatch, 2 timer, 3 field select, 4 exit set,
//   5 inc, 6 dec/clear, 7 start/stop.
//  Mode changes: press0/1/2 from any state except TM_ALARM go to WATCH/SW_IDLE/TM_SET_M.
//   sw_run and tm_run hold their values (counters keep running in the background).
//  States (code):
//   WATCH(0): press3 -> WSET_H.
//   WSET_H(1): press3 -> WSET_M; press5/6 -> inc_p/dec_p; press4 -> WATCH.
//   WSET_M(2): press3 -> WSET_H; press5/6 -> inc_p/dec_p; press4 -> WATCH.
//   SW_IDLE(3): press7 -> SW_RUN (sw_run=1); press6 -> sw_clr.
//   SW_RUN(4): press7 -> SW_IDLE (sw_run=0); press6 is ignored.
//   TM_SET_M(5) / TM_SET_S(6): press3 swaps the two; press5/6 -> inc_p/dec_p;
//    press7 with tm_zero=0 -> TM_RUN (tm_run=1); press7 with tm_zero=1 is ignored.
//   TM_RUN(7): press7 -> TM_SET_M (tm_run=0, pause). tm_zero=1 -> TM_ALARM with tm_run=0.
//    The tm_zero transition is taken from any state whenever tm_run=1.
//   TM_ALARM(8, shown as led=8'h80 | mode bits unchanged): speaker toggles every TONE_DIV cycles.
//    Any press -> TM_SET_M with speaker=0. After ALARM_TICKS tick_1hz pulses -> TM_SET_M.
//  set_field: 1 in WSET_H/TM_SET_M, 2 in WSET_M/TM_SET_S, 0 otherwise.
//   blink resets to 0 on entry to a set state.
//  mode: 0 for states 0-2, 1 for states 3-4, 2 for states 5-8.
//  Wrap and saturation of field values are owned by the datapath; this block only strobes.
//  Counters: tone counter and alarm tick counter clear on entry to TM_ALARM.
//  Reset mid-operation: rst is asynchronous and returns all outputs to the reset values above.
//   Active run flags and the alarm are dropped.
// TESTING
//  1. rst pulse, btn=0 -> mode=0, led=8'h01, speaker=0, no strobes.
//  2. btn=8 held 3 clk, released, repeated 3 times -> WSET_H, WSET_M, WSET_H.
//     Then btn=32 -> exactly one inc_p with set_field=1.
//     Then btn=16 -> WATCH.
//  3. btn=2, then btn=128 held 40 clk -> SW_RUN with a single toggle (sw_run=1).
//     Second btn=128 -> sw_run=0. btn=64 -> one sw_clr.
//  4. btn=4, inc_p via btn=32, start via btn=128 -> tm_run=1.
//     Force tm_zero=1 -> next clk tm_run=0, speaker toggling with period 2*TONE_DIV.
//  5. In TM_ALARM: send 10 tick_1hz -> speaker=0, state TM_SET_M.
//     Repeat the alarm, then btn=16 -> immediate silence.
//  6. btn=2|8 pressed together -> only STOPWATCH taken.
//     Assert rst while SW_RUN -> sw_run=0, led=8'h01 asynchronously.

Source files
------------

// File: rtl/mode_sequencer.sv
// Central controller of the watch: debounces the buttons, runs the mode/setting FSM,
// issues one-cycle strobes to the counter datapaths and drives the LEDs and speaker.
module mode_sequencer #(
  parameter int DEB_CYCLES  = 2,
  parameter int TONE_DIV    = 4,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  input  logic       tick_1hz,
  input  logic       tm_zero,
  output logic [1:0] mode,
  output logic [1:0] set_field,
  output logic       inc_p,
  output logic       dec_p,
  output logic       sw_run,
  output logic       sw_clr,
  output logic       tm_run,
  output logic       blink,
  output logic       speaker,
  output logic [7:0] led
);

  localparam logic [3:0] ST_WATCH    = 4'd0;
  localparam logic [3:0] ST_WSET_H   = 4'd1;
  localparam logic [3:0] ST_WSET_M   = 4'd2;
  localparam logic [3:0] ST_SW_IDLE  = 4'd3;
  localparam logic [3:0] ST_SW_RUN   = 4'd4;
  localparam logic [3:0] ST_TM_SET_M = 4'd5;
  localparam logic [3:0] ST_TM_SET_S = 4'd6;
  localparam logic [3:0] ST_TM_RUN   = 4'd7;
  localparam logic [3:0] ST_TM_ALARM = 4'd8;

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TONE_DIV + 1);
  localparam int KW = $clog2(ALARM_TICKS + 1);
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [KW-1:0] TICK_LAST = KW'(ALARM_TICKS - 1);

  logic [CW-1:0] deb_cnt [8];
  logic [7:0]    press_q;
  logic [3:0]    state, state_n;
  logic          sel_valid;
  logic [2:0]    sel_idx;
  logic          sw_run_n, tm_run_n, inc_n, dec_n, clr_n, blink_n;
  logic          alarm_done, set_now, set_next;
  logic [TW-1:0] tone_cnt;
  logic [KW-1:0] tick_cnt;

  // Counter saturates at DEB_MAX so a held button yields exactly one press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q <= '0;
      for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        press_q[i] <= btn[i] && (deb_cnt[i] == DEB_LAST);
        if (!btn[i])                deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DEB_MAX) deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (press_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  assign alarm_done = (state == ST_TM_ALARM) && tick_1hz && (tick_cnt == TICK_LAST);

  always_comb begin
    state_n  = state;
    sw_run_n = sw_run;
    tm_run_n = tm_run;
    inc_n    = 1'b0;
    dec_n    = 1'b0;
    clr_n    = 1'b0;
    if (tm_run && tm_zero) begin
      state_n  = ST_TM_ALARM;
      tm_run_n = 1'b0;
    end else if (state == ST_TM_ALARM) begin
      if (sel_valid || alarm_done) state_n = ST_TM_SET_M;
    end else if (sel_valid && sel_idx <= 3'd2) begin
      case (sel_idx)
        3'd0:    state_n = ST_WATCH;
        3'd1:    state_n = ST_SW_IDLE;
        default: state_n = ST_TM_SET_M;
      endcase
    end else if (sel_valid) begin
      case (state)
        ST_WATCH: if (sel_idx == 3'd3) state_n = ST_WSET_H;
        ST_WSET_H, ST_WSET_M: begin
          case (sel_idx)
            3'd3:    state_n = (state == ST_WSET_H) ? ST_WSET_M : ST_WSET_H;
            3'd4:    state_n = ST_WATCH;
            3'd5:    inc_n = 1'b1;
            3'd6:    dec_n = 1'b1;
            default: ;
          endcase
        end
        ST_SW_IDLE: begin
          if (sel_idx == 3'd7) begin
            state_n  = ST_SW_RUN;
            sw_run_n = 1'b1;
          end else if (sel_idx == 3'd6) begin
            clr_n = 1'b1;
          end
        end
        ST_SW_RUN: begin
          if (sel_idx == 3'd7) begin
            state_n  = ST_SW_IDLE;
            sw_run_n = 1'b0;
          end
        end
        ST_TM_SET_M, ST_TM_SET_S: begin
          case (sel_idx)
            3'd3:    state_n = (state == ST_TM_SET_M) ? ST_TM_SET_S : ST_TM_SET_M;
            3'd5:    inc_n = 1'b1;
            3'd6:    dec_n = 1'b1;
            3'd7: begin
              if (!tm_zero) begin
                state_n  = ST_TM_RUN;
                tm_run_n = 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_TM_RUN: begin
          if (sel_idx == 3'd7) begin
            state_n  = ST_TM_SET_M;
            tm_run_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign set_now  = (state == ST_WSET_H) || (state == ST_WSET_M) ||
                    (state == ST_TM_SET_M) || (state == ST_TM_SET_S);
  assign set_next = (state_n == ST_WSET_H) || (state_n == ST_WSET_M) ||
                    (state_n == ST_TM_SET_M) || (state_n == ST_TM_SET_S);

  // Blink phase restarts on every entry into an edit state, including field swaps.
  always_comb begin
    blink_n = 1'b0;
    if (set_next && (state_n == state) && set_now)
      blink_n = tick_1hz ? ~blink : blink;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_WATCH;
      sw_run <= 1'b0;
      tm_run <= 1'b0;
      inc_p  <= 1'b0;
      dec_p  <= 1'b0;
      sw_clr <= 1'b0;
      blink  <= 1'b0;
    end else begin
      state  <= state_n;
      sw_run <= sw_run_n;
      tm_run <= tm_run_n;
      inc_p  <= inc_n;
      dec_p  <= dec_n;
      sw_clr <= clr_n;
      blink  <= blink_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt <= '0;
      tick_cnt <= '0;
      speaker  <= 1'b0;
    end else if ((state == ST_TM_ALARM) && (state_n == ST_TM_ALARM)) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        speaker  <= ~speaker;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
      if (tick_1hz) tick_cnt <= tick_cnt + 1'b1;
    end else begin
      tone_cnt <= '0;
      tick_cnt <= '0;
      speaker  <= 1'b0;
    end
  end

  assign led       = (state > ST_TM_RUN) ? 8'h80 : (8'h01 << state);
  assign mode      = (state <= ST_WSET_M) ? 2'd0 : (state <= ST_SW_RUN) ? 2'd1 : 2'd2;
  assign set_field = ((state == ST_WSET_H) || (state == ST_TM_SET_M)) ? 2'd1 :
                     ((state == ST_WSET_M) || (state == ST_TM_SET_S)) ? 2'd2 : 2'd0;

endmodule

// File: tb/tb_mode_sequencer.sv
// Testbench for mode_sequencer: directed scenarios plus randomized button/tick
// traffic checked against a cycle-level behavioural model of the controller.
module tb_mode_sequencer;

  localparam int DEB   = 2;
  localparam int TONE  = 4;
  localparam int TICKS = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic       tick_1hz, tm_zero;
  logic [1:0] mode, set_field;
  logic       inc_p, dec_p, sw_run, sw_clr, tm_run, blink, speaker;
  logic [7:0] led;

  int vectors     = 0;
  int miscompares = 0;
  int inc_seen = 0, dec_seen = 0, clr_seen = 0;

  mode_sequencer #(.DEB_CYCLES(DEB), .TONE_DIV(TONE), .ALARM_TICKS(TICKS)) dut (
    .clk(clk), .rst(rst), .btn(btn), .tick_1hz(tick_1hz), .tm_zero(tm_zero),
    .mode(mode), .set_field(set_field), .inc_p(inc_p), .dec_p(dec_p),
    .sw_run(sw_run), .sw_clr(sw_clr), .tm_run(tm_run), .blink(blink),
    .speaker(speaker), .led(led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_p)  inc_seen++;
    if (dec_p)  dec_seen++;
    if (sw_clr) clr_seen++;
  end

  // Behavioural model: watch states named by the codes the controller reports.
  typedef enum int {M_WATCH, M_WSET_H, M_WSET_M, M_SW_IDLE, M_SW_RUN,
                    M_TM_SET_M, M_TM_SET_S, M_TM_RUN, M_TM_ALARM} mstate_t;
  mstate_t m_state;
  bit m_sw_run, m_tm_run, m_blink, m_inc, m_dec, m_clr;
  int held [8];
  bit pend [8];
  int alarm_k, alarm_ticks;

  function automatic bit is_edit(mstate_t s);
    return s == M_WSET_H || s == M_WSET_M || s == M_TM_SET_M || s == M_TM_SET_S;
  endfunction

  task automatic model_step();
    int p;
    mstate_t prev;
    if (rst) begin
      m_state = M_WATCH;
      {m_sw_run, m_tm_run, m_blink, m_inc, m_dec, m_clr} = '0;
      for (int i = 0; i < 8; i++) begin held[i] = 0; pend[i] = 0; end
      alarm_k = 0; alarm_ticks = 0;
      return;
    end
    p = -1;
    for (int i = 0; i < 8; i++) if (pend[i] && p < 0) p = i;
    prev = m_state;
    m_inc = 0; m_dec = 0; m_clr = 0;
    if (m_tm_run && tm_zero) begin
      m_state = M_TM_ALARM; m_tm_run = 0; alarm_k = 0; alarm_ticks = 0;
    end else if (m_state == M_TM_ALARM) begin
      if (tick_1hz) alarm_ticks++;
      if (p >= 0 || alarm_ticks == TICKS) m_state = M_TM_SET_M;
      else alarm_k++;
    end else if (p == 0) m_state = M_WATCH;
    else if (p == 1) m_state = M_SW_IDLE;
    else if (p == 2) m_state = M_TM_SET_M;
    else if (p >= 3) begin
      case (m_state)
        M_WATCH:    if (p == 3) m_state = M_WSET_H;
        M_WSET_H:   begin if (p == 3) m_state = M_WSET_M; if (p == 4) m_state = M_WATCH;
                          m_inc = (p == 5); m_dec = (p == 6); end
        M_WSET_M:   begin if (p == 3) m_state = M_WSET_H; if (p == 4) m_state = M_WATCH;
                          m_inc = (p == 5); m_dec = (p == 6); end
        M_SW_IDLE:  begin if (p == 7) begin m_state = M_SW_RUN; m_sw_run = 1; end
                          m_clr = (p == 6); end
        M_SW_RUN:   if (p == 7) begin m_state = M_SW_IDLE; m_sw_run = 0; end
        M_TM_SET_M: begin if (p == 3) m_state = M_TM_SET_S;
                          if (p == 7 && !tm_zero) begin m_state = M_TM_RUN; m_tm_run = 1; end
                          m_inc = (p == 5); m_dec = (p == 6); end
        M_TM_SET_S: begin if (p == 3) m_state = M_TM_SET_M;
                          if (p == 7 && !tm_zero) begin m_state = M_TM_RUN; m_tm_run = 1; end
                          m_inc = (p == 5); m_dec = (p == 6); end
        M_TM_RUN:   if (p == 7) begin m_state = M_TM_SET_M; m_tm_run = 0; end
        default: ;
      endcase
    end
    if (!is_edit(m_state) || m_state != prev) m_blink = 0;
    else if (tick_1hz) m_blink = !m_blink;
    for (int i = 0; i < 8; i++) begin
      held[i] = btn[i] ? held[i] + 1 : 0;
      pend[i] = (held[i] == DEB);
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  function automatic logic [18:0] model_vec();
    logic [1:0] md, sf;
    logic [7:0] ld;
    logic spk;
    int code = int'(m_state);
    md  = (code <= 2) ? 2'd0 : (code <= 4) ? 2'd1 : 2'd2;
    sf  = (m_state == M_WSET_H || m_state == M_TM_SET_M) ? 2'd1 :
          (m_state == M_WSET_M || m_state == M_TM_SET_S) ? 2'd2 : 2'd0;
    ld  = 8'h01 << ((code > 7) ? 7 : code);
    spk = (m_state == M_TM_ALARM) ? 1'((alarm_k / TONE) % 2) : 1'b0;
    return {md, sf, ld, m_sw_run, m_tm_run, m_blink, spk, m_inc, m_dec, m_clr};
  endfunction

  task automatic press_btn(input logic [7:0] mask, input int hold);
    @(negedge clk) btn = mask;
    repeat (hold) @(negedge clk);
    btn = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 8'h00; tick_1hz = 1'b0; tm_zero = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mode, set_field, led} !== {2'd0, 2'd0, 8'h01}) begin
      miscompares++;
      $display("[TB] FAIL reset_disp got %h exp %h", {mode, set_field, led}, {2'd0, 2'd0, 8'h01});
    end
    vectors++;
    if ({inc_p, dec_p, sw_clr, sw_run, tm_run, blink, speaker} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b exp 0000000",
               {inc_p, dec_p, sw_clr, sw_run, tm_run, blink, speaker});
    end
  endtask

  task automatic test_watch_set();
    logic [7:0] exp_led [3];
    int i0;
    exp_led[0] = 8'h02; exp_led[1] = 8'h04; exp_led[2] = 8'h02;
    for (int i = 0; i < 3; i++) begin
      press_btn(8'h08, 3);
      vectors++;
      if (led !== exp_led[i]) begin
        miscompares++;
        $display("[TB] FAIL field_sel%0d led got %h exp %h", i, led, exp_led[i]);
      end
    end
    i0 = inc_seen;
    press_btn(8'h20, 3);
    vectors++;
    if (inc_seen - i0 !== 1 || set_field !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL wset_inc pulses got %0d field %0d exp 1 field 1", inc_seen - i0, set_field);
    end
    press_btn(8'h10, 3);
    vectors++;
    if ({mode, led} !== {2'd0, 8'h01}) begin
      miscompares++;
      $display("[TB] FAIL wset_exit got %h exp %h", {mode, led}, {2'd0, 8'h01});
    end
  endtask

  task automatic test_stopwatch();
    int c0;
    press_btn(8'h02, 3);
    press_btn(8'h80, 40);
    vectors++;
    if ({sw_run, led} !== {1'b1, 8'h10}) begin
      miscompares++;
      $display("[TB] FAIL sw_start got %h exp %h", {sw_run, led}, {1'b1, 8'h10});
    end
    c0 = clr_seen;
    press_btn(8'h40, 3);
    vectors++;
    if (clr_seen - c0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL sw_clr_while_run got %0d exp 0", clr_seen - c0);
    end
    press_btn(8'h80, 3);
    vectors++;
    if ({sw_run, led} !== {1'b0, 8'h08}) begin
      miscompares++;
      $display("[TB] FAIL sw_stop got %h exp %h", {sw_run, led}, {1'b0, 8'h08});
    end
    press_btn(8'h40, 3);
    vectors++;
    if (clr_seen - c0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL sw_clr got %0d exp 1", clr_seen - c0);
    end
  endtask

  task automatic test_timer_alarm();
    int i0;
    press_btn(8'h04, 3);
    vectors++;
    if ({mode, set_field, led} !== {2'd2, 2'd1, 8'h20}) begin
      miscompares++;
      $display("[TB] FAIL tm_enter got %h exp %h", {mode, set_field, led}, {2'd2, 2'd1, 8'h20});
    end
    i0 = inc_seen;
    press_btn(8'h20, 3);
    press_btn(8'h80, 3);
    vectors++;
    if ({tm_run, led, inc_seen - i0} !== {1'b1, 8'h80, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL tm_start run %b led %h inc %0d exp 1 80 1", tm_run, led, inc_seen - i0);
    end
    tm_zero = 1'b1;
    @(negedge clk) tm_zero = 1'b0;
    vectors++;
    if ({tm_run, speaker, led} !== {1'b0, 1'b0, 8'h80}) begin
      miscompares++;
      $display("[TB] FAIL alarm_entry got %h exp %h", {tm_run, speaker, led}, {1'b0, 1'b0, 8'h80});
    end
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if (speaker !== 1'((k / TONE) % 2)) begin
        miscompares++;
        $display("[TB] FAIL tone k=%0d got %b exp %b", k, speaker, 1'((k / TONE) % 2));
      end
    end
  endtask

  task automatic test_alarm_ticks();
    for (int t = 1; t <= TICKS; t++) begin
      tick_1hz = 1'b1;
      @(negedge clk) tick_1hz = 1'b0;
      if (t == TICKS - 1) begin
        vectors++;
        if (led !== 8'h80) begin
          miscompares++;
          $display("[TB] FAIL alarm_hold_9 got %h exp 80", led);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if ({led, speaker, blink} !== {8'h20, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL alarm_timeout got %h exp %h", {led, speaker, blink}, {8'h20, 1'b0, 1'b0});
    end
    tm_zero = 1'b1;
    press_btn(8'h80, 3);
    tm_zero = 1'b0;
    vectors++;
    if ({tm_run, led} !== {1'b0, 8'h20}) begin
      miscompares++;
      $display("[TB] FAIL start_at_zero got %h exp %h", {tm_run, led}, {1'b0, 8'h20});
    end
    press_btn(8'h80, 3);
    tm_zero = 1'b1;
    @(negedge clk) tm_zero = 1'b0;
    repeat (3) @(negedge clk);
    press_btn(8'h10, 3);
    vectors++;
    if ({led, speaker, tm_run} !== {8'h20, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL alarm_press_stop got %h exp %h", {led, speaker, tm_run}, {8'h20, 1'b0, 1'b0});
    end
  endtask

  task automatic test_priority_and_async_reset();
    press_btn(8'h0A, 3);
    vectors++;
    if ({mode, set_field, led} !== {2'd1, 2'd0, 8'h08}) begin
      miscompares++;
      $display("[TB] FAIL priority got %h exp %h", {mode, set_field, led}, {2'd1, 2'd0, 8'h08});
    end
    press_btn(8'h80, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sw_run, led} !== {1'b0, 8'h01}) begin
      miscompares++;
      $display("[TB] FAIL async_reset got %h exp %h", {sw_run, led}, {1'b0, 8'h01});
    end
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [18:0] act, exp;
    int hold;
    for (int n = 0; n < 700; n++) begin
      btn  = 8'($urandom & $urandom & $urandom);
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        tick_1hz = ($urandom_range(0, 7) == 0);
        tm_zero  = ($urandom_range(0, 5) == 0);
        @(negedge clk);
        act = {mode, set_field, led, sw_run, tm_run, blink, speaker, inc_p, dec_p, sw_clr};
        exp = model_vec();
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("[TB] FAIL random n=%0d got %h exp %h", n, act, exp);
        end
      end
    end
    btn = 8'h00; tick_1hz = 1'b0; tm_zero = 1'b0;
  endtask

  initial begin
    test_reset();
    test_watch_set();
    test_stopwatch();
    test_timer_alarm();
    test_alarm_ticks();
    test_priority_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
